// File: rtl/contador_pkg.sv
// Shared constants for the contador family: count direction and end-of-range policy.
package contador_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int POL_WRAP = 0;
  localparam int POL_SAT  = 1;

endpackage

// File: rtl/contador_ud_bin2gray.sv
// Binary to reflected Gray code; purely combinational.
module bin2gray #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  for (genvar i = 0; i < WIDTH - 1; i++) begin : g_bit
    assign gray[i] = bin[i] ^ bin[i+1];
  end
  assign gray[WIDTH-1] = bin[WIDTH-1];

endmodule

// File: rtl/contador_ud.sv
// Up/down modulo counter with load, enable, wrap/saturate policy, Gray output,
// terminal-count pulse and sticky overflow flag.
module contador_ud
  import contador_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULO   = 2**WIDTH,
  parameter int SATURATE = POL_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             w,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_gray,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 2 || MODULO < 2 || MODULO > 2**WIDTH) begin : g_bad_param
    $error("contador_ud: need WIDTH>=2 and 2 <= MODULO <= 2**WIDTH");
  end

  // One extra bit so MODULO itself (up to 2**WIDTH) is representable.
  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MODULO - 1);
  localparam bit             SAT   = (SATURATE == POL_SAT);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   cur, nxt;
  logic             evt;

  always_comb begin
    cur   = {1'b0, q_q};
    nxt   = cur;
    evt   = 1'b0;
    if (load) begin
      nxt = ({1'b0, d} >= MOD_W) ? MAX_W : {1'b0, d};
    end else if (en) begin
      if (w == DIR_UP) begin
        if (cur >= MAX_W) begin
          evt = 1'b1;
          nxt = SAT ? MAX_W : '0;
        end else begin
          nxt = cur + 1'b1;
        end
      end else begin
        if (cur == '0) begin
          evt = 1'b1;
          nxt = SAT ? '0 : MAX_W;
        end else begin
          nxt = cur - 1'b1;
        end
      end
    end
    q_d   = nxt[WIDTH-1:0];
    tc_d  = evt;
    // A new event outranks a simultaneous clear.
    ovf_d = evt | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  bin2gray #(.WIDTH(WIDTH)) u_gray (
    .bin  (q_q),
    .gray (q_gray)
  );

  assign q   = q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_contador_ud.sv
// Scoreboard bench for contador_ud: a wrapping and a saturating instance share stimulus.
module tb_contador_ud;

  typedef struct packed {
    logic       sel;   // 0 = wrap instance, 1 = saturate instance
    logic [2:0] q;
    logic       tc;
    logic       ovf;
    logic [2:0] g;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, w, load, clr_ovf;
  logic [2:0] d;
  logic [2:0] qa, ga, qb, gb;
  logic       tca, ovfa, tcb, ovfb;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  contador_ud #(.WIDTH(3), .MODULO(6), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .w(w), .load(load), .d(d), .clr_ovf(clr_ovf),
    .q(qa), .q_gray(ga), .tc(tca), .ovf(ovfa)
  );

  contador_ud #(.WIDTH(3), .MODULO(6), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .w(w), .load(load), .d(d), .clr_ovf(clr_ovf),
    .q(qb), .q_gray(gb), .tc(tcb), .ovf(ovfb)
  );

  function automatic exp_t X(input logic sel, input logic [2:0] q, input logic tc,
                             input logic ovf, input logic [2:0] g);
    return '{sel: sel, q: q, tc: tc, ovf: ovf, g: g};
  endfunction

  function automatic exp_t obs(input logic sel);
    return sel ? '{sel: 1'b1, q: qb, tc: tcb, ovf: ovfb, g: gb}
               : '{sel: 1'b0, q: qa, tc: tca, ovf: ovfa, g: ga};
  endfunction

  task automatic apply(input logic r, input logic e, input logic wd, input logic l,
                       input logic [2:0] dv, input logic c);
    rst = r; en = e; w = wd; load = l; d = dv; clr_ovf = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    apply(0, 0, 1, 0, 3'd0, 0);
    sb.push_back(X(0, 3'd0, 0, 0, 3'd0));
    sb.push_back(X(1, 3'd0, 0, 0, 3'd0));
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(e.sel); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset[sel%0d]: got q=%0d tc=%b ovf=%b g=%0d, expected q=%0d tc=%b ovf=%b g=%0d",
                 e.sel, o.q, o.tc, o.ovf, o.g, e.q, e.tc, e.ovf, e.g);
      end
    end
  endtask

  task automatic test_wrap_up();
    logic [2:0] qs[7]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    logic [2:0] gs[7]  = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd0, 3'd1};
    logic       tcs[7] = '{0, 0, 0, 0, 0, 1, 0};
    logic       ovs[7] = '{0, 0, 0, 0, 0, 1, 1};
    exp_t e, o;
    for (int i = 0; i < 7; i++) begin
      apply(1, 1, 1, 0, 3'd0, 0);
      sb.push_back(X(0, qs[i], tcs[i], ovs[i], gs[i]));
      tick();
      e = sb.pop_front(); o = obs(e.sel); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap_up[%0d]: got q=%0d tc=%b ovf=%b g=%0d, expected q=%0d tc=%b ovf=%b g=%0d",
                 i, o.q, o.tc, o.ovf, o.g, e.q, e.tc, e.ovf, e.g);
      end
    end
  endtask

  task automatic test_wrap_down_clr();
    // Down from 1 across the 0 boundary, then a clear on a quiet edge.
    logic [2:0] qs[4]  = '{3'd0, 3'd5, 3'd4, 3'd4};
    logic [2:0] gs[4]  = '{3'd0, 3'd7, 3'd6, 3'd6};
    logic       tcs[4] = '{0, 1, 0, 0};
    logic       ovs[4] = '{1, 1, 1, 0};
    exp_t e, o;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) apply(1, 1, 0, 0, 3'd0, 0);
      else       apply(1, 0, 0, 0, 3'd0, 1);
      sb.push_back(X(0, qs[i], tcs[i], ovs[i], gs[i]));
      tick();
      e = sb.pop_front(); o = obs(e.sel); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap_down[%0d]: got q=%0d tc=%b ovf=%b g=%0d, expected q=%0d tc=%b ovf=%b g=%0d",
                 i, o.q, o.tc, o.ovf, o.g, e.q, e.tc, e.ovf, e.g);
      end
    end
  endtask

  task automatic test_saturate();
    // Saturating instance: its ovf was cleared at the end of the previous test.
    // Steps: load 4; up x4; clr while saturating; quiet clr; load 0; down at 0; quiet clr.
    logic [2:0] qs[10]  = '{3'd4, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd0, 3'd0, 3'd0};
    logic [2:0] gs[10]  = '{3'd6, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0};
    logic       tcs[10] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 0};
    logic       ovs[10] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 0};
    exp_t e, o;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0:       apply(1, 0, 1, 1, 3'd4, 0);
        5:       apply(1, 1, 1, 0, 3'd0, 1);
        6:       apply(1, 0, 1, 0, 3'd0, 1);
        7:       apply(1, 0, 0, 1, 3'd0, 0);
        8:       apply(1, 1, 0, 0, 3'd0, 0);
        9:       apply(1, 0, 0, 0, 3'd0, 1);
        default: apply(1, 1, 1, 0, 3'd0, 0);
      endcase
      sb.push_back(X(1, qs[i], tcs[i], ovs[i], gs[i]));
      tick();
      e = sb.pop_front(); o = obs(e.sel); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL saturate[%0d]: got q=%0d tc=%b ovf=%b g=%0d, expected q=%0d tc=%b ovf=%b g=%0d",
                 i, o.q, o.tc, o.ovf, o.g, e.q, e.tc, e.ovf, e.g);
      end
    end
  endtask

  task automatic test_load();
    exp_t e, o;
    // Clear the wrap instance's flag first so load is seen not to set it.
    apply(1, 0, 1, 0, 3'd0, 1);
    tick();
    // Out-of-range load clamps to MODULO-1 on both instances.
    apply(1, 0, 1, 1, 3'd7, 0);
    sb.push_back(X(0, 3'd5, 0, 0, 3'd7));
    sb.push_back(X(1, 3'd5, 0, 0, 3'd7));
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs(e.sel); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL load_clamp[sel%0d]: got q=%0d tc=%b ovf=%b g=%0d, expected q=%0d tc=%b ovf=%b g=%0d",
                 e.sel, o.q, o.tc, o.ovf, o.g, e.q, e.tc, e.ovf, e.g);
      end
    end
    // Load beats enable, even at the top of range where counting would be an event.
    apply(1, 1, 1, 1, 3'd2, 0);
    sb.push_back(X(0, 3'd2, 0, 0, 3'd3));
    tick();
    e = sb.pop_front(); o = obs(e.sel); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL load_vs_en: got q=%0d tc=%b ovf=%b g=%0d, expected q=%0d tc=%b ovf=%b g=%0d",
               o.q, o.tc, o.ovf, o.g, e.q, e.tc, e.ovf, e.g);
    end
  endtask

  task automatic test_toggle();
    logic [2:0] qs[5] = '{3'd3, 3'd4, 3'd3, 3'd4, 3'd3};
    logic [2:0] gs[5] = '{3'd2, 3'd6, 3'd2, 3'd6, 3'd2};
    exp_t e, o;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) apply(1, 0, 0, 1, 3'd3, 0);
      else        apply(1, 1, (i % 2) == 1, 0, 3'd0, 0);
      sb.push_back(X(0, qs[i], 0, 0, gs[i]));
      tick();
      e = sb.pop_front(); o = obs(e.sel); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL toggle[%0d]: got q=%0d tc=%b ovf=%b g=%0d, expected q=%0d tc=%b ovf=%b g=%0d",
                 i, o.q, o.tc, o.ovf, o.g, e.q, e.tc, e.ovf, e.g);
      end
    end
  endtask

  task automatic test_reset_mid();
    // load 5; up (event); load 4; reset with en+load high; resume counting.
    logic [2:0] qs[5]  = '{3'd5, 3'd0, 3'd4, 3'd0, 3'd1};
    logic [2:0] gs[5]  = '{3'd7, 3'd0, 3'd6, 3'd0, 3'd1};
    logic       tcs[5] = '{0, 1, 0, 0, 0};
    logic       ovs[5] = '{0, 1, 1, 0, 0};
    exp_t e, o;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       apply(1, 0, 1, 1, 3'd5, 0);
        1:       apply(1, 1, 1, 0, 3'd0, 0);
        2:       apply(1, 0, 1, 1, 3'd4, 0);
        3:       apply(0, 1, 1, 1, 3'd2, 0);
        default: apply(1, 1, 1, 0, 3'd0, 0);
      endcase
      sb.push_back(X(0, qs[i], tcs[i], ovs[i], gs[i]));
      tick();
      e = sb.pop_front(); o = obs(e.sel); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got q=%0d tc=%b ovf=%b g=%0d, expected q=%0d tc=%b ovf=%b g=%0d",
                 i, o.q, o.tc, o.ovf, o.g, e.q, e.tc, e.ovf, e.g);
      end
    end
  endtask

  initial begin
    apply(0, 0, 1, 0, 3'd0, 0);
    #2;
    test_reset();
    test_wrap_up();
    test_wrap_down_clr();
    test_saturate();
    test_load();
    test_toggle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
